// File: rtl/neighbor_table_pq.sv
// rtl/neighbor_table_pq.sv - neighbor table with ID-keyed upsert, heartbeat aging and best-next-hop scan
//
// Stores up to DEPTH neighbor records. A write either updates the record
// holding node_id or allocates the lowest free slot. age_tick ages every
// entry, and an entry is evicted when its age reaches MAX_AGE. A background
// scan keeps best_* on the entry with the highest Q-value, preferring fewer
// hops and then the lower slot.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   wr_en, node_*               upsert request and record fields
//   hb_reset                    clears the whole table (wins over wr_en/age_tick)
//   age_tick                    heartbeat window pulse
//   rd_en, rd_idx               read request; rd_valid/rd_* registered one cycle later
//   neighbor_count, full, drop  occupancy status; drop pulses on a rejected new ID
//   best_valid, best_*          latched best-entry summary
//   scan_busy                   best_* stale while high
module neighbor_table_pq #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int AGE_WIDTH  = 3,
  parameter int MAX_AGE    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         hb_reset,
  input  logic                         age_tick,
  input  logic [WORD_WIDTH-1:0]        node_id,
  input  logic [WORD_WIDTH-1:0]        node_hops,
  input  logic [WORD_WIDTH-1:0]        node_qvalue,
  input  logic [WORD_WIDTH-1:0]        node_energy,
  input  logic [WORD_WIDTH-1:0]        node_chhops,
  input  logic                         rd_en,
  input  logic [$clog2(DEPTH)-1:0]     rd_idx,
  output logic                         rd_valid,
  output logic [WORD_WIDTH-1:0]        rd_id,
  output logic [WORD_WIDTH-1:0]        rd_hops,
  output logic [WORD_WIDTH-1:0]        rd_qvalue,
  output logic [WORD_WIDTH-1:0]        rd_energy,
  output logic [WORD_WIDTH-1:0]        rd_chhops,
  output logic [$clog2(DEPTH+1)-1:0]   neighbor_count,
  output logic                         full,
  output logic                         drop,
  output logic                         best_valid,
  output logic [WORD_WIDTH-1:0]        best_id,
  output logic [WORD_WIDTH-1:0]        best_qvalue,
  output logic [WORD_WIDTH-1:0]        best_hops,
  output logic                         scan_busy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [AGE_WIDTH:0]   EVICT_AGE = (AGE_WIDTH + 1)'(MAX_AGE);

  typedef enum logic [1:0] {IDLE, SCAN, LATCH} scanState_t;

  logic [DEPTH-1:0]      valid, validNext;
  logic [AGE_WIDTH-1:0]  age     [DEPTH];
  logic [AGE_WIDTH-1:0]  ageNext [DEPTH];
  logic [WORD_WIDTH-1:0] idMem     [DEPTH];
  logic [WORD_WIDTH-1:0] hopsMem   [DEPTH];
  logic [WORD_WIDTH-1:0] qMem      [DEPTH];
  logic [WORD_WIDTH-1:0] energyMem [DEPTH];
  logic [WORD_WIDTH-1:0] chHopsMem [DEPTH];

  logic             hitAny, freeAny, doWrite, evictAny, tableChange;
  logic [IDX_W-1:0] hitIdx, freeIdx, wrSlot;
  logic [CNT_W-1:0] countNext;

  // Descending loop so the lowest matching / free index is the one kept.
  always_comb begin
    hitAny  = 1'b0;
    hitIdx  = '0;
    freeAny = 1'b0;
    freeIdx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && idMem[i] == node_id) begin
        hitAny = 1'b1;
        hitIdx = IDX_W'(i);
      end
      if (!valid[i]) begin
        freeAny = 1'b1;
        freeIdx = IDX_W'(i);
      end
    end
  end

  // Allocation is decided on pre-tick state, so slots freed by a same-cycle
  // tick cannot absorb this write.
  always_comb begin
    validNext = valid;
    evictAny  = 1'b0;
    wrSlot    = hitAny ? hitIdx : freeIdx;
    doWrite   = wr_en && !hb_reset && (hitAny || freeAny);
    for (int i = 0; i < DEPTH; i++) begin
      ageNext[i] = age[i];
      if (hb_reset) begin
        validNext[i] = 1'b0;
        ageNext[i]   = '0;
      end else if (doWrite && wrSlot == IDX_W'(i)) begin
        validNext[i] = 1'b1;
        ageNext[i]   = '0;
      end else if (age_tick && valid[i]) begin
        if ({1'b0, age[i]} + (AGE_WIDTH + 1)'(1) == EVICT_AGE) begin
          validNext[i] = 1'b0;
          evictAny     = 1'b1;
        end
        if (age[i] != '1) ageNext[i] = age[i] + AGE_WIDTH'(1);
      end
    end
    tableChange = hb_reset || doWrite || evictAny;
    countNext   = '0;
    for (int i = 0; i < DEPTH; i++) countNext = countNext + CNT_W'(validNext[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid          <= '0;
      neighbor_count <= '0;
      drop           <= 1'b0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      valid          <= validNext;
      neighbor_count <= countNext;
      drop           <= wr_en && !hb_reset && !hitAny && !freeAny;
      for (int i = 0; i < DEPTH; i++) age[i] <= ageNext[i];
    end
  end

  // Record fields are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      idMem[wrSlot]     <= node_id;
      hopsMem[wrSlot]   <= node_hops;
      qMem[wrSlot]      <= node_qvalue;
      energyMem[wrSlot] <= node_energy;
      chHopsMem[wrSlot] <= node_chhops;
    end
  end

  assign full = (neighbor_count == FULL_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      rd_id     <= '0;
      rd_hops   <= '0;
      rd_qvalue <= '0;
      rd_energy <= '0;
      rd_chhops <= '0;
    end else if (rd_en) begin
      rd_valid  <= valid[rd_idx];
      rd_id     <= idMem[rd_idx];
      rd_hops   <= hopsMem[rd_idx];
      rd_qvalue <= qMem[rd_idx];
      rd_energy <= energyMem[rd_idx];
      rd_chhops <= chHopsMem[rd_idx];
    end
  end

  // Scan: any table change (re)starts at slot 0 on the same edge, so the
  // pending flag never outlives a cycle and busy reduces to state != IDLE.
  scanState_t            state, stateNext;
  logic [IDX_W-1:0]      scanIdx, scanIdxNext;
  logic                  accumulate, latchBest, priorValid, slotBeats;
  logic                  runValid;
  logic [WORD_WIDTH-1:0] runId, runQ, runHops;

  always_comb begin
    stateNext   = state;
    scanIdxNext = scanIdx;
    accumulate  = 1'b0;
    latchBest   = 1'b0;
    case (state)
      IDLE: begin
        if (tableChange) begin
          stateNext   = SCAN;
          scanIdxNext = '0;
        end
      end
      SCAN: begin
        if (tableChange) begin
          scanIdxNext = '0;
        end else begin
          accumulate = 1'b1;
          if (scanIdx == LAST_IDX) stateNext = LATCH;
          else scanIdxNext = scanIdx + IDX_W'(1);
        end
      end
      LATCH: begin
        latchBest   = 1'b1;
        scanIdxNext = '0;
        stateNext   = tableChange ? SCAN : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Slot 0 starts a fresh running best; equal Q and hops never beat, which
  // keeps the lower index.
  always_comb begin
    priorValid = (scanIdx == '0) ? 1'b0 : runValid;
    slotBeats  = valid[scanIdx] &&
                 (!priorValid || qMem[scanIdx] > runQ ||
                  (qMem[scanIdx] == runQ && hopsMem[scanIdx] < runHops));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      scanIdx     <= '0;
      runValid    <= 1'b0;
      runId       <= '0;
      runQ        <= '0;
      runHops     <= '1;
      best_valid  <= 1'b0;
      best_id     <= '0;
      best_qvalue <= '0;
      best_hops   <= '1;
    end else begin
      state   <= stateNext;
      scanIdx <= scanIdxNext;
      if (accumulate) begin
        runValid <= priorValid || valid[scanIdx];
        if (slotBeats) begin
          runId   <= idMem[scanIdx];
          runQ    <= qMem[scanIdx];
          runHops <= hopsMem[scanIdx];
        end
      end
      if (latchBest) begin
        best_valid  <= runValid;
        best_id     <= runValid ? runId : '0;
        best_qvalue <= runValid ? runQ : '0;
        best_hops   <= runValid ? runHops : '1;
      end
    end
  end

  assign scan_busy = (state != IDLE);

endmodule

// File: tb/tb_neighbor_table_pq.sv
// tb/tb_neighbor_table_pq.sv - scoreboard bench for neighbor_table_pq
module tb_neighbor_table_pq;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, hb_reset = 1'b0, age_tick = 1'b0, rd_en = 1'b0;
  logic [15:0] node_id = '0, node_hops = '0, node_qvalue = '0, node_energy = '0, node_chhops = '0;
  logic [4:0]  rd_idx = '0;
  logic        rd_valid, full, drop, best_valid, scan_busy;
  logic [15:0] rd_id, rd_hops, rd_qvalue, rd_energy, rd_chhops;
  logic [15:0] best_id, best_qvalue, best_hops;
  logic [5:0]  neighbor_count;

  neighbor_table_pq #(.WORD_WIDTH(16), .DEPTH(DEPTH), .AGE_WIDTH(3), .MAX_AGE(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .hb_reset(hb_reset), .age_tick(age_tick),
    .node_id(node_id), .node_hops(node_hops), .node_qvalue(node_qvalue),
    .node_energy(node_energy), .node_chhops(node_chhops),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_id(rd_id), .rd_hops(rd_hops),
    .rd_qvalue(rd_qvalue), .rd_energy(rd_energy), .rd_chhops(rd_chhops),
    .neighbor_count(neighbor_count), .full(full), .drop(drop),
    .best_valid(best_valid), .best_id(best_id), .best_qvalue(best_qvalue),
    .best_hops(best_hops), .scan_busy(scan_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        chkData;
    logic [15:0] id;
    logic [15:0] q;
    logic [15:0] hops;
  } exp_t;

  exp_t readQ[$];
  exp_t bestQ[$];
  int   checks = 0;
  int   errors = 0;
  logic rdLat = 1'b0;
  logic prevBusy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) rdLat <= rd_en;

  // Monitor: read responses one cycle after rd_en; best summary on scan_busy falling.
  always @(negedge clk) begin
    exp_t e;
    if (rdLat) begin
      if (readQ.size() == 0) begin
        check("read_unexpected", 1, 0);
      end else begin
        e = readQ.pop_front();
        check("rd_valid", rd_valid, e.v);
        if (e.chkData) begin
          check("rd_id", rd_id, e.id);
          check("rd_qvalue", rd_qvalue, e.q);
          check("rd_hops", rd_hops, e.hops);
        end
      end
    end
    if (prevBusy && !scan_busy && bestQ.size() > 0) begin
      e = bestQ.pop_front();
      check("best_valid", best_valid, e.v);
      check("best_id", best_id, e.id);
      check("best_qvalue", best_qvalue, e.q);
      check("best_hops", best_hops, e.hops);
    end
    prevBusy = scan_busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeRec(input logic [15:0] id, input logic [15:0] q, input logic [15:0] hops);
    wr_en = 1'b1; node_id = id; node_qvalue = q; node_hops = hops;
    node_energy = id ^ 16'h00FF; node_chhops = hops + 16'd1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pushRead(input logic v, input logic chk, input logic [15:0] id,
                          input logic [15:0] q, input logic [15:0] hops);
    exp_t e;
    e.v = v; e.chkData = chk; e.id = id; e.q = q; e.hops = hops;
    readQ.push_back(e);
  endtask

  task automatic readSlot(input int idx, input logic v, input logic chk, input logic [15:0] id,
                          input logic [15:0] q, input logic [15:0] hops);
    pushRead(v, chk, id, q, hops);
    rd_en = 1'b1; rd_idx = 5'(idx);
    step();
    rd_en = 1'b0;
  endtask

  task automatic expectBest(input logic v, input logic [15:0] id, input logic [15:0] q,
                            input logic [15:0] hops);
    exp_t e;
    e.v = v; e.chkData = 1'b1; e.id = id; e.q = q; e.hops = hops;
    bestQ.push_back(e);
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    @(negedge clk);
    while (scan_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (scan_busy) check("scan_timeout", 1, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_count"}, neighbor_count, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_drop"}, drop, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_id"}, rd_id, 0);
    check({tag, "_best_valid"}, best_valid, 0);
    check({tag, "_best_id"}, best_id, 0);
    check({tag, "_best_qvalue"}, best_qvalue, 0);
    check({tag, "_best_hops"}, best_hops, 16'hFFFF);
    check({tag, "_scan_busy"}, scan_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkResetOutputs("reset");

    // Basic inserts and best selection
    writeRec(16'd5, 16'h0100, 16'd3);
    writeRec(16'd9, 16'h0300, 16'd2);
    writeRec(16'd12, 16'h0200, 16'd4);
    check("count_after_3", neighbor_count, 3);
    expectBest(1'b1, 16'd9, 16'h0300, 16'd2);
    waitIdle(n);
    check("latency_first", n, DEPTH + 1);

    // In-place update and hops tie-break
    writeRec(16'd9, 16'h0050, 16'd2);
    check("count_after_rewrite", neighbor_count, 3);
    expectBest(1'b1, 16'd12, 16'h0200, 16'd4);
    waitIdle(n);
    readSlot(1, 1'b1, 1'b1, 16'd9, 16'h0050, 16'd2);
    writeRec(16'd7, 16'h0200, 16'd1);
    check("count_after_id7", neighbor_count, 4);
    expectBest(1'b1, 16'd7, 16'h0200, 16'd1);
    waitIdle(n);

    // Read and write of the same slot in one cycle returns pre-write data
    pushRead(1'b1, 1'b1, 16'd5, 16'h0100, 16'd3);
    wr_en = 1'b1; node_id = 16'd5; node_qvalue = 16'h0110; node_hops = 16'd3;
    rd_en = 1'b1; rd_idx = 5'd0;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    expectBest(1'b1, 16'd7, 16'h0200, 16'd1);
    waitIdle(n);
    readSlot(0, 1'b1, 1'b1, 16'd5, 16'h0110, 16'd3);

    // Aging: ID 9 refreshed on every tick, others evicted on the 4th
    for (int k = 1; k <= 4; k++) begin
      age_tick = 1'b1; wr_en = 1'b1;
      node_id = 16'd9; node_qvalue = 16'h0050; node_hops = 16'd2;
      step();
      check($sformatf("count_tick%0d", k), neighbor_count, (k < 4) ? 4 : 1);
    end
    age_tick = 1'b0; wr_en = 1'b0;
    expectBest(1'b1, 16'd9, 16'h0050, 16'd2);
    waitIdle(n);
    readSlot(0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    readSlot(1, 1'b1, 1'b1, 16'd9, 16'h0050, 16'd2);
    readSlot(2, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);

    // Fill the table, then a new ID is dropped and an existing one accepted
    for (int i = 0; i < 31; i++) writeRec(16'(100 + i), 16'(16'h10 + i), 16'd5);
    check("count_full", neighbor_count, 32);
    check("full_flag", full, 1);
    expectBest(1'b1, 16'd9, 16'h0050, 16'd2);
    waitIdle(n);
    writeRec(16'd99, 16'h0900, 16'd1);
    check("drop_pulse", drop, 1);
    check("count_after_drop", neighbor_count, 32);
    check("busy_after_drop", scan_busy, 0);
    step();
    check("drop_cleared", drop, 0);
    readSlot(31, 1'b1, 1'b1, 16'd130, 16'h002E, 16'd5);
    writeRec(16'd115, 16'h0400, 16'd1);
    check("drop_on_hit_full", drop, 0);
    check("count_hit_full", neighbor_count, 32);
    expectBest(1'b1, 16'd115, 16'h0400, 16'd1);
    waitIdle(n);
    readSlot(16, 1'b1, 1'b1, 16'd115, 16'h0400, 16'd1);

    // hb_reset beats write and tick
    wr_en = 1'b1; age_tick = 1'b1; hb_reset = 1'b1;
    node_id = 16'd200; node_qvalue = 16'h0001; node_hops = 16'd1;
    step();
    wr_en = 1'b0; age_tick = 1'b0; hb_reset = 1'b0;
    check("count_hb_reset", neighbor_count, 0);
    check("full_hb_reset", full, 0);
    check("drop_hb_reset", drop, 0);
    expectBest(1'b0, 16'd0, 16'd0, 16'hFFFF);
    waitIdle(n);
    readSlot(16, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);

    // Write during a scan restarts it
    writeRec(16'd1, 16'h0005, 16'd1);
    repeat (10) step();
    writeRec(16'd2, 16'h0006, 16'd1);
    expectBest(1'b1, 16'd2, 16'h0006, 16'd1);
    waitIdle(n);
    check("busy_cycles_after_restart", n, DEPTH + 1);
    readSlot(0, 1'b1, 1'b1, 16'd1, 16'h0005, 16'd1);

    // Asynchronous reset mid-scan
    writeRec(16'd3, 16'h0700, 16'd1);
    repeat (5) step();
    check("busy_mid_scan", scan_busy, 1);
    #2 rst = 1'b1;
    #1 checkResetOutputs("async_rst");
    step();
    rst = 1'b0;
    repeat (40) step();
    check("no_latch_busy", scan_busy, 0);
    check("no_latch_best_valid", best_valid, 0);
    check("no_latch_best_hops", best_hops, 16'hFFFF);
    readSlot(2, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    step();

    check("read_queue_drained", readQ.size(), 0);
    check("best_queue_drained", bestQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
